vector_load_unit: RTL and testbench
===================================

VECTOR_LOAD_UNIT -- requirements
Module: vector_load_unit

Interface
REQ-001 Parameters SHALL be: LANES, 16, vector lanes; DW, 32, lane data width; AW, 32, memory address width.
REQ-002 Ports SHALL be:
- clk  in  1  the single clock.
- rst_n  in  1  reset, asynchronous, active-low.
REQ-003 The design SHALL use one clock (clk); reset (rst_n) is asynchronous and active-low.
REQ-004 Command ports SHALL be:
- start  in  1  begin a vector fetch.
- base_addr  in  AW  address of lane 0.
- stride  in  AW  byte increment between lanes.
- busy  out  1  fetch in progress.
- done  out  1  one-cycle completion pulse.
REQ-005 Memory ports SHALL be:
- mem_req  out  1  read request.
- mem_addr  out  AW  read address.
- mem_gnt  in  1  request accepted.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  DW  read data.
REQ-006 Vector ports SHALL be:
- vec_out  out  LANES*DW  assembled vector, lane i at bits [i*DW +: DW].
- load  out  1  capture strobe to the downstream vector register.

Function
REQ-007 The FSM SHALL have exactly three states: IDLE, FETCH, LOAD.
REQ-008 In IDLE, start=1 SHALL latch base_addr and stride, clear both counters, set busy=1 and move to FETCH on the same edge.
REQ-009 start SHALL be ignored whenever busy=1.
REQ-010 In FETCH, mem_req SHALL be high while issue_cnt < LANES.
REQ-011 mem_addr SHALL equal base + issue_cnt*stride, computed modulo 2^AW; wrap-around is legal.
REQ-012 mem_req=1 with mem_gnt=1 SHALL increment issue_cnt; mem_req and mem_addr SHALL hold unchanged until gnt.
REQ-013 Responses SHALL return in order; mem_rvalid=1 SHALL write mem_rdata into lane recv_cnt and increment recv_cnt.
REQ-014 A grant and a response in the same cycle SHALL both take effect.
REQ-015 mem_rvalid SHALL be ignored in IDLE and LOAD, and when recv_cnt = LANES.
REQ-016 When recv_cnt reaches LANES, FETCH SHALL move to LOAD on the next edge.
REQ-017 In LOAD, load=1 and done=1 SHALL be asserted for exactly one cycle, then the FSM SHALL return to IDLE with busy=0.
REQ-018 vec_out SHALL be stable from the cycle before load rises until the next start, so the downstream edge capture is glitch-free.
REQ-019 stride=0 SHALL be legal: all lanes read the same address.
REQ-020 Minimum latency: with mem_gnt tied high and rvalid one cycle after gnt, start accepted at edge 0 SHALL give load high in cycle 18.
REQ-021 load, done, busy and mem_req SHALL be registered outputs.

Reset
REQ-022 rst_n=0 SHALL immediately force state IDLE, busy=0, done=0, load=0, mem_req=0, mem_addr=0, counters=0 and vec_out=0.
REQ-023 Reset mid-FETCH SHALL abort the fetch without asserting load; in-flight responses arriving after reset SHALL be discarded per REQ-015.

Structure
REQ-024 A shared package vec_pkg SHALL hold LANES, DW, AW and the FSM state enumeration; the downstream vector register SHALL use the same constants.
REQ-025 One sub-module, vec_capture (a LANES x DW register bank with write enable and lane index), SHALL hold vec_out; everything else stays in vector_load_unit.

Verification
REQ-026 base=0x1000, stride=4, gnt=1, rvalid one cycle later with data=addr -> lane i=0x1000+4i, load pulses once in cycle 18, done coincides.
REQ-027 base=0xFFFFFFF8, stride=4 -> lane 2 address 0x00000000, lane 15 address 0x00000034.
REQ-028 gnt low for 3 cycles on lane 5 -> mem_addr held at base+20, no lane skipped, load delayed by exactly 3 cycles.
REQ-029 start pulsed during FETCH, plus spurious rvalid in IDLE -> no restart, vec_out unchanged, no extra load.
REQ-030 rst_n low after 7 responses -> outputs zero, no load, later rvalids ignored; a new start completes normally.
REQ-031 stride=0, base=0x40 -> all 16 requests to 0x40, lanes hold the returned data in response order.

Source files
------------

// File: rtl/vec_pkg.sv
//------------------------------------------------------------------------------
// vec_pkg : constants and FSM states shared by the vector load unit
//           and the downstream vector register.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package vec_pkg;
   localparam int LANES = 16;
   localparam int DW    = 32;
   localparam int AW    = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      LOAD  = 2'd2
   } state_t;
endpackage

`default_nettype wire

// File: rtl/vec_capture.sv
//------------------------------------------------------------------------------
// vec_capture : LANES x DW register bank, one lane written per cycle.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module vec_capture
   import vec_pkg::*;
#(
   parameter int LANES = vec_pkg::LANES,
   parameter int DW    = vec_pkg::DW,
   parameter int IW    = (LANES > 1) ? $clog2(LANES) : 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                we,
   input  logic [IW-1:0]       idx,
   input  logic [DW-1:0]       wdata,
   output logic [LANES*DW-1:0] vec
);

   // Packed layout puts lane i at bits [i*DW +: DW] of vec.
   logic [LANES-1:0][DW-1:0] r_bank;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bank <= '0;
      end else if (we) begin
         r_bank[idx] <= wdata;
      end
   end

   assign vec = r_bank;

endmodule

`default_nettype wire

// File: rtl/vector_load_unit.sv
//------------------------------------------------------------------------------
// vector_load_unit : strided gather of LANES words into a vector register.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module vector_load_unit
   import vec_pkg::*;
#(
   parameter int LANES = vec_pkg::LANES,
   parameter int DW    = vec_pkg::DW,
   parameter int AW    = vec_pkg::AW
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [AW-1:0]       base_addr,
   input  logic [AW-1:0]       stride,
   output logic                busy,
   output logic                done,
   output logic                mem_req,
   output logic [AW-1:0]       mem_addr,
   input  logic                mem_gnt,
   input  logic                mem_rvalid,
   input  logic [DW-1:0]       mem_rdata,
   output logic [LANES*DW-1:0] vec_out,
   output logic                load
);

   localparam int CW = $clog2(LANES + 1);
   localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;

   state_t        r_state;
   logic [AW-1:0] r_stride;
   logic [CW-1:0] r_issue_cnt;
   logic [CW-1:0] r_recv_cnt;
   logic          w_capture;

   // Responses are only accepted while a fetch still expects data.
   assign w_capture = (r_state == FETCH) && mem_rvalid && (r_recv_cnt != CW'(LANES));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_stride    <= '0;
         r_issue_cnt <= '0;
         r_recv_cnt  <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         load        <= 1'b0;
         mem_req     <= 1'b0;
         mem_addr    <= '0;
      end else begin
         done <= 1'b0;
         load <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_state     <= FETCH;
                  r_stride    <= stride;
                  r_issue_cnt <= '0;
                  r_recv_cnt  <= '0;
                  busy        <= 1'b1;
                  mem_req     <= 1'b1;
                  mem_addr    <= base_addr;
               end
            end
            FETCH: begin
               // Running sum equals base + issue_cnt*stride modulo 2^AW.
               if (mem_req && mem_gnt) begin
                  r_issue_cnt <= r_issue_cnt + 1'b1;
                  mem_addr    <= mem_addr + r_stride;
                  if (r_issue_cnt == CW'(LANES - 1)) begin
                     mem_req <= 1'b0;
                  end
               end
               if (w_capture) begin
                  r_recv_cnt <= r_recv_cnt + 1'b1;
               end
               if (r_recv_cnt == CW'(LANES)) begin
                  r_state <= LOAD;
                  load    <= 1'b1;
                  done    <= 1'b1;
               end
            end
            LOAD: begin
               r_state <= IDLE;
               busy    <= 1'b0;
            end
            default: begin
               r_state <= IDLE;
               busy    <= 1'b0;
               mem_req <= 1'b0;
            end
         endcase
      end
   end

   vec_capture #(
      .LANES (LANES),
      .DW    (DW),
      .IW    (IW)
   ) u_capture (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (w_capture),
      .idx   (r_recv_cnt[IW-1:0]),
      .wdata (mem_rdata),
      .vec   (vec_out)
   );

endmodule

`default_nettype wire

// File: tb/tb_vector_load_unit.sv
//------------------------------------------------------------------------------
// tb_vector_load_unit : directed table, corner sequences and random fetches
//                       against a lane-arithmetic reference model.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_vector_load_unit;
   import vec_pkg::*;

   localparam int VW = LANES * DW;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [AW-1:0] base_addr;
   logic [AW-1:0] stride;
   logic          busy;
   logic          done;
   logic          mem_req;
   logic [AW-1:0] mem_addr;
   logic          mem_gnt;
   logic          mem_rvalid;
   logic [DW-1:0] mem_rdata;
   logic [VW-1:0] vec_out;
   logic          load;

   vector_load_unit #(.LANES(LANES), .DW(DW), .AW(AW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .base_addr  (base_addr),
      .stride     (stride),
      .busy       (busy),
      .done       (done),
      .mem_req    (mem_req),
      .mem_addr   (mem_addr),
      .mem_gnt    (mem_gnt),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata),
      .vec_out    (vec_out),
      .load       (load)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      int          ready;
   } pend_t;

   typedef struct {
      logic [31:0] base;
      logic [31:0] stride;
      int          mode;
      int          stall_lane;
      int          stall_len;
      logic [31:0] key;
      logic [31:0] mult;
      int          l1;
      logic [31:0] a1;
      int          l2;
      logic [31:0] a2;
      int          exp_lat;
   } vec_t;

   int checks = 0;
   int errors = 0;

   // Memory model and monitor state
   pend_t         pq[$];
   int            cyc = 0;
   int            gmode = 0;
   int            stall_lane = 0;
   int            stall_left = 0;
   logic [31:0]   key = '0;
   logic [31:0]   mult = '0;
   int            seq = 0;
   int            nissue = 0;
   int            issue_err = 0;
   int            hold_err = 0;
   int            load_count = 0;
   int            load_cyc = 0;
   int            done_err = 0;
   int            stable_err = 0;
   bit            spur_req = 1'b0;
   bit            prev_wait = 1'b0;
   logic [31:0]   wait_addr = '0;
   logic [31:0]   stall_addr = '0;
   logic [31:0]   exp_base = '0;
   logic [31:0]   exp_stride = '0;
   logic [31:0]   iss_addr [LANES];
   logic [VW-1:0] prev_vec = '0;
   logic [VW-1:0] load_vec = '0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      logic  g;
      pend_t p;
      if (load) begin
         load_count++;
         load_cyc = cyc;
         if (!done) done_err++;
         if (vec_out !== prev_vec) stable_err++;
         load_vec = vec_out;
      end else if (done) begin
         done_err++;
      end
      prev_vec = vec_out;

      if (rst_n && prev_wait && (!mem_req || mem_addr !== wait_addr)) hold_err++;

      mem_rvalid = 1'b0;
      mem_rdata  = $urandom;
      if (pq.size() > 0 && pq[0].ready <= cyc) begin
         p          = pq.pop_front();
         mem_rvalid = 1'b1;
         mem_rdata  = p.addr ^ key ^ (32'(seq) * mult);
         seq++;
      end else if (spur_req) begin
         mem_rvalid = 1'b1;
         mem_rdata  = 32'hDEADBEEF;
         spur_req   = 1'b0;
      end

      g = 1'b1;
      if (gmode == 1) begin
         if (mem_req && nissue == stall_lane && stall_left > 0) begin
            g = 1'b0;
            stall_left--;
            stall_addr = mem_addr;
         end
      end else if (gmode == 2) begin
         g = ($urandom_range(0, 9) < 7);
      end
      mem_gnt   = g;
      prev_wait = rst_n && mem_req && !g;
      wait_addr = mem_addr;
      if (mem_req && g) begin
         if (nissue < LANES) iss_addr[nissue] = mem_addr;
         if (mem_addr !== exp_base + 32'(nissue) * exp_stride) issue_err++;
         pq.push_back('{mem_addr, cyc + 1 + ((gmode == 2) ? int'($urandom_range(0, 2)) : 0)});
         nissue++;
      end
   end

   function automatic logic [VW-1:0] model_vec(input logic [31:0] b, s, k, m);
      logic [VW-1:0] v;
      v = '0;
      for (int i = 0; i < LANES; i++) begin
         v[i*DW +: DW] = (b + 32'(i) * s) ^ k ^ (32'(i) * m);
      end
      return v;
   endfunction

   task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_idle(input string tag);
      bit to;
      to = 1'b1;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (!busy && pq.size() == 0) begin
            to = 1'b0;
            break;
         end
      end
      if (to) chk({tag, "_idle_timeout"}, 1, 0);
   endtask

   task automatic run_fetch(input string tag, input logic [31:0] b, s, input int mode, sl, sn,
                            input logic [31:0] k, m, input int mid, output int lat);
      int  c0;
      bit  to;
      wait_idle(tag);
      gmode      = mode;
      stall_lane = sl;
      stall_left = sn;
      key        = k;
      mult       = m;
      seq        = 0;
      nissue     = 0;
      issue_err  = 0;
      load_count = 0;
      done_err   = 0;
      stable_err = 0;
      exp_base   = b;
      exp_stride = s;
      @(negedge clk);
      start     = 1'b1;
      base_addr = b;
      stride    = s;
      c0        = cyc;
      @(negedge clk);
      start     = 1'b0;
      base_addr = $urandom;
      stride    = $urandom;
      if (mid >= 0) begin
         repeat (mid) @(negedge clk);
         if (busy) begin
            start     = 1'b1;
            base_addr = 32'h9000;
            stride    = 32'h10;
            @(negedge clk);
            start = 1'b0;
         end
      end
      to = 1'b1;
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         if (load_count > 0 && !busy) begin
            to = 1'b0;
            break;
         end
      end
      repeat (3) @(negedge clk);
      lat = load_cyc - c0 - 1;
      chk({tag, "_timeout"}, VW'(to), 0);
      chk({tag, "_vec"}, load_vec, model_vec(b, s, k, m));
      chk({tag, "_loads"}, VW'(load_count), 1);
      chk({tag, "_issued"}, VW'(nissue), VW'(LANES));
      chk({tag, "_addr_err"}, VW'(issue_err), 0);
      chk({tag, "_done_err"}, VW'(done_err), 0);
      chk({tag, "_stable_err"}, VW'(stable_err), 0);
   endtask

   vec_t tbl[4];

   initial begin
      int            lat;
      logic [VW-1:0] held;
      logic [31:0]   rb, rs;

      tbl[0] = '{32'h1000,     32'd4, 0, 0, 0, 32'h0,        32'h0,        7, 32'h101C, 15, 32'h103C, 18};
      tbl[1] = '{32'hFFFFFFF8, 32'd4, 0, 0, 0, 32'h5A5A0000, 32'h0,        2, 32'h0,    15, 32'h34,   18};
      tbl[2] = '{32'h1000,     32'd4, 1, 5, 3, 32'h0,        32'h0,        5, 32'h1014,  6, 32'h1018, 21};
      tbl[3] = '{32'h40,       32'd0, 0, 0, 0, 32'h0,        32'h01000001, 0, 32'h40,   15, 32'h40,   18};

      rst_n     = 1'b0;
      start     = 1'b0;
      base_addr = '0;
      stride    = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", VW'(busy), 0);
      chk("rst_done", VW'(done), 0);
      chk("rst_load", VW'(load), 0);
      chk("rst_req", VW'(mem_req), 0);
      chk("rst_addr", VW'(mem_addr), 0);
      chk("rst_vec", vec_out, 0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 4; i++) begin
         run_fetch($sformatf("tbl%0d", i), tbl[i].base, tbl[i].stride, tbl[i].mode,
                   tbl[i].stall_lane, tbl[i].stall_len, tbl[i].key, tbl[i].mult, -1, lat);
         chk($sformatf("tbl%0d_latency", i), VW'(lat), VW'(tbl[i].exp_lat));
         chk($sformatf("tbl%0d_lane%0d_addr", i, tbl[i].l1), VW'(iss_addr[tbl[i].l1]), VW'(tbl[i].a1));
         chk($sformatf("tbl%0d_lane%0d_addr", i, tbl[i].l2), VW'(iss_addr[tbl[i].l2]), VW'(tbl[i].a2));
         if (tbl[i].mode == 1) chk("stall_held_addr", VW'(stall_addr), VW'(tbl[i].a1));
      end

      // Spurious rvalid in IDLE, then start pulsed mid-fetch.
      held       = model_vec(tbl[3].base, tbl[3].stride, tbl[3].key, tbl[3].mult);
      load_count = 0;
      spur_req   = 1'b1;
      repeat (4) @(negedge clk);
      chk("spur_idle_vec", vec_out, held);
      chk("spur_idle_load", VW'(load_count), 0);
      run_fetch("midstart", 32'h3000, 32'h8, 0, 0, 0, 32'h0, 32'h0, 5, lat);
      chk("midstart_latency", VW'(lat), 18);
      load_count = 0;
      spur_req   = 1'b1;
      repeat (4) @(negedge clk);
      chk("spur_after_vec", vec_out, model_vec(32'h3000, 32'h8, 32'h0, 32'h0));
      chk("spur_after_load", VW'(load_count), 0);

      // Reset after seven responses.
      wait_idle("rstseq");
      gmode = 0; key = '0; mult = '0; seq = 0; nissue = 0; load_count = 0;
      exp_base = 32'h2000; exp_stride = 32'h8; issue_err = 0;
      @(negedge clk);
      start = 1'b1; base_addr = 32'h2000; stride = 32'h8;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 100 && seq < 7; i++) @(negedge clk);
      chk("rstseq_seq", VW'(seq), 7);
      rst_n = 1'b0;
      #1;
      chk("rstseq_busy", VW'(busy), 0);
      chk("rstseq_req", VW'(mem_req), 0);
      chk("rstseq_addr", VW'(mem_addr), 0);
      chk("rstseq_vec", vec_out, 0);
      chk("rstseq_load", VW'({load, done}), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      wait_idle("rstseq_drain");
      repeat (3) @(negedge clk);
      chk("rstseq_vec_after", vec_out, 0);
      chk("rstseq_no_load", VW'(load_count), 0);
      run_fetch("post_rst", 32'h2000, 32'h8, 0, 0, 0, 32'h1234, 32'h0, -1, lat);
      chk("post_rst_latency", VW'(lat), 18);

      // Randomised fetches with irregular grant and response timing.
      for (int n = 0; n < 20; n++) begin
         rb = $urandom;
         case ($urandom_range(0, 3))
            0:       rs = 32'h0;
            1:       rs = 32'h4;
            2:       rs = 32'hFFFFFFFC;
            default: rs = $urandom;
         endcase
         run_fetch($sformatf("rand%0d", n), rb, rs, 2, 0, 0, $urandom, $urandom,
                   ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 20)) : -1, lat);
      end

      chk("mem_hold_err", VW'(hold_err), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
